handshake_const_arb: RTL and testbench
======================================

HANDSHAKE_CONST_ARB -- requirements
Module: handshake_const_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of control requesters (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the constant width.
REQ-003 SHALL have parameter CONSTS, default entry i = 8'h44 + i zero-extended, a flattened NUM_REQ*DATA_WIDTH vector where entry i is the constant for requester i (bits i*DATA_WIDTH upward).
REQ-004 SHALL derive local IDX_W = max(1, clog2(NUM_REQ)).
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ctrl_valid, input, NUM_REQ: per-requester control token valid.
REQ-008 SHALL have port ctrl_ready, output, NUM_REQ: per-requester token accepted.
REQ-009 SHALL have port outs, output, DATA_WIDTH: the issued constant.
REQ-010 SHALL have port outs_idx, output, IDX_W: the index of the requester that owns outs.
REQ-011 SHALL have port outs_valid, output, 1: output token valid.
REQ-012 SHALL have port outs_ready, input, 1: the consumer accepts the output token.

Function
REQ-013 SHALL hold a one-entry output register (full flag, data, idx) that drives outs/outs_idx/outs_valid directly; outs_valid = full.
REQ-014 SHALL be able to accept a token (can_acc) when the register is not full, or when it is full and outs_ready=1.
REQ-015 SHALL select a winner round-robin: the search starts at pointer ptr, ascending modulo NUM_REQ, and takes the first asserted ctrl_valid.
REQ-016 SHALL assert ctrl_ready[i] only when i is the winner and can_acc=1; at most one bit SHALL be high; ctrl_ready SHALL be all-zero when no ctrl_valid is high.
REQ-017 SHALL, on a ctrl handshake with winner k: load data=CONSTS[k] and idx=k, set full, and set ptr to (k+1) mod NUM_REQ at the next edge.
REQ-018 SHALL leave ptr unchanged when no handshake occurs.
REQ-019 SHALL have a latency of 1 cycle from the ctrl handshake edge to outs_valid, and sustain a throughput of 1 token per cycle.
REQ-020 SHALL, when full, outs_ready=1 and a winner exists, drain and refill in the same cycle, with outs_valid staying 1.
REQ-021 SHALL clear full when full, outs_ready=1 and there is no winner.
REQ-022 SHALL hold outs and outs_idx stable while outs_valid=1 and outs_ready=0, and deassert all ctrl_ready in that state.
REQ-023 SHALL have no combinational path from ctrl_valid or outs_ready to outs, outs_idx or outs_valid.
REQ-024 SHALL treat a ctrl_valid that drops without a handshake as withdrawn, with no state change.

Reset
REQ-025 SHALL, while rst=0 and independent of clk, force full=0, outs_valid=0, outs=0, outs_idx=0, ptr=0, and all ctrl_ready=0.
REQ-026 SHALL discard any token held in the register when reset is asserted mid-operation; no token SHALL be replayed after reset.
REQ-027 SHALL first accept a token on the first rising edge after rst returns to 1.

Configuration
REQ-028 SHALL, when macro HANDSHAKE_CONST_ARB_ISSUE_CNT_EN is defined, add output port issue_cnt, 16 bits, which counts output handshakes (outs_valid & outs_ready), wraps from 16'hFFFF to 0, and resets to 0.
REQ-029 SHALL, when HANDSHAKE_CONST_ARB_ISSUE_CNT_EN is undefined, omit the port and the counter, with all other behaviour identical.

Structure
REQ-030 SHALL take the shared constants (default base constant 8'h44, issue-counter width 16) from package handshake_pkg.
REQ-031 SHALL put the round-robin selection in sub-module rr_arbiter (inputs: req vector, ptr; outputs: one-hot grant, binary index, any).
REQ-032 SHALL keep the output register, ptr and the counter in handshake_const_arb.

Verification (NUM_REQ=4, DATA_WIDTH=32, default CONSTS)
REQ-033 SHALL cover: rst=0 with ctrl_valid=4'b1111 -> outs_valid=0, outs=0, ctrl_ready=4'b0000 with no clock edge needed.
REQ-034 SHALL cover: after reset, ctrl_valid=4'b0100 and outs_ready=1 for 1 cycle -> ctrl_ready=4'b0100, then next cycle outs=32'h46, outs_idx=2, outs_valid=1, and ptr=3.
REQ-035 SHALL cover: ctrl_valid=4'b1111 held with outs_ready=1 -> outs_idx sequence 0,1,2,3,0 with outs 32'h44,45,46,47,44, one per cycle.
REQ-036 SHALL cover: register full and outs_ready=0 for 5 cycles -> outs and outs_idx stable and ctrl_ready=0; raising outs_ready with ctrl_valid=4'b0010 -> drain and refill the same cycle, outs_idx=1 next.
REQ-037 SHALL cover: rst pulled low mid-stream between clock edges -> outs_valid drops immediately; after release with ctrl_valid=4'b1111 -> first outs_idx=0.
REQ-038 SHALL cover: with HANDSHAKE_CONST_ARB_ISSUE_CNT_EN, 10 output handshakes -> issue_cnt=10; with preload 16'hFFFF plus 1 handshake -> issue_cnt=0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared constants for the handshake constant arbiter slice.
//   BASE_CONST   : value of requester 0's default constant; requester i gets BASE_CONST + i
//   ISSUE_CNT_W  : width of the optional output-handshake counter
//   default_consts(): builds the default flattened constant table
package handshake_pkg;

  localparam int unsigned BASE_CONST  = 32'h44;
  localparam int unsigned ISSUE_CNT_W = 16;

  // Widest table default_consts() can build (16 requesters x 256 bits).
  localparam int unsigned CONST_MAX_W = 4096;

  // Entry i = BASE_CONST + i, masked to w bits, at bit offset i*w.
  function automatic logic [CONST_MAX_W-1:0] default_consts(input int unsigned n,
                                                              input int unsigned w);
    logic [CONST_MAX_W-1:0] res;
    logic [CONST_MAX_W-1:0] mask;
    logic [CONST_MAX_W-1:0] val;
    res  = '0;
    mask = (CONST_MAX_W'(1) << w) - CONST_MAX_W'(1);
    for (int unsigned i = 0; i < n; i++) begin
      val = CONST_MAX_W'(BASE_CONST + i) & mask;
      res = res | (val << (i * w));
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches req ascending from ptr (mod NUM_REQ) and
// returns the first asserted requester. Purely combinational.
//   req     : request vector
//   ptr     : index where the search starts
//   grant_c : one-hot grant (all zero when nothing requests)
//   idx_c   : binary index of the granted requester
//   any_c   : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  int unsigned j;

  // First-hit search; any_c blocks later hits so the grant stays one-hot.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    j       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      j = (32'(ptr) + off) % NUM_REQ;
      if (!any_c && req[j]) begin
        any_c      = 1'b1;
        grant_c[j] = 1'b1;
        idx_c      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/handshake_const_arb.sv
// Round-robin arbiter that turns per-requester control tokens into the
// requester's constant, held in a one-entry output register.
// Optional feature: define HANDSHAKE_CONST_ARB_ISSUE_CNT_EN to add issue_cnt,
// a wrapping count of output handshakes.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   ctrl_valid : per-requester token valid
//   ctrl_ready : per-requester token accepted (at most one bit high)
//   outs       : issued constant
//   outs_idx   : requester that owns outs
//   outs_valid : output token valid
//   outs_ready : consumer accepts the output token
//   issue_cnt  : (optional) output handshake count
module handshake_const_arb
  import handshake_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS =
    (NUM_REQ*DATA_WIDTH)'(default_consts(NUM_REQ, DATA_WIDTH)),
  localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_idx,
  output logic                  outs_valid,
`ifdef HANDSHAKE_CONST_ARB_ISSUE_CNT_EN
  output logic [ISSUE_CNT_W-1:0] issue_cnt,
`endif
  input  logic                  outs_ready
);

  logic                  full;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      ptr;

  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  any_c;
  logic                  can_acc_c;
  logic                  ctrl_hs_c;
  logic [IDX_W-1:0]      ptr_next_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (ctrl_valid),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (win_idx_c),
    .any_c   (any_c)
  );

  // Register can take a token when empty or when it drains this cycle.
  assign can_acc_c  = !full || outs_ready;
  // Gated by rst so ctrl_ready is low during reset without a clock edge.
  assign ctrl_hs_c  = any_c && can_acc_c && rst;
  assign ctrl_ready = ctrl_hs_c ? grant_c : '0;

  assign ptr_next_c = (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      ptr    <= '0;
    end else if (ctrl_hs_c) begin
      full   <= 1'b1;
      data_q <= CONSTS[win_idx_c*DATA_WIDTH +: DATA_WIDTH];
      idx_q  <= win_idx_c;
      ptr    <= ptr_next_c;
    end else if (outs_ready) begin
      full   <= 1'b0;
    end
  end

  assign outs       = data_q;
  assign outs_idx   = idx_q;
  assign outs_valid = full;

`ifdef HANDSHAKE_CONST_ARB_ISSUE_CNT_EN
  // Wrapping count of output handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
    end else if (full && outs_ready) begin
      issue_cnt <= issue_cnt + ISSUE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_handshake_const_arb.sv
// Directed bench for handshake_const_arb (NUM_REQ=4, DATA_WIDTH=32, default constants).
module tb_handshake_const_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [31:0] outs;
  logic [1:0]  outs_idx;
  logic        outs_valid;
  logic        outs_ready;
`ifdef HANDSHAKE_CONST_ARB_ISSUE_CNT_EN
  logic [15:0] issue_cnt;
`endif

  int n_tests;
  int n_fail;

  handshake_const_arb #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_idx   (outs_idx),
    .outs_valid (outs_valid),
`ifdef HANDSHAKE_CONST_ARB_ISSUE_CNT_EN
    .issue_cnt  (issue_cnt),
`endif
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset asserted before any clock edge.
    rst        = 1'b0;
    ctrl_valid = 4'b1111;
    outs_ready = 1'b1;
    #2;
    check("rst_outs_valid", 32'(outs_valid), 32'h0);
    check("rst_outs",       outs,            32'h0);
    check("rst_outs_idx",   32'(outs_idx),   32'h0);
    check("rst_ctrl_ready", 32'(ctrl_ready), 32'h0);

    step();
    step();
    ctrl_valid = 4'b0000;
    rst        = 1'b1;

    // Single requester 2.
    ctrl_valid = 4'b0100;
    #1;
    check("single_ready", 32'(ctrl_ready), 32'h4);
    step();
    ctrl_valid = 4'b0000;
    check("single_outs",  outs,            32'h46);
    check("single_idx",   32'(outs_idx),   32'h2);
    check("single_valid", 32'(outs_valid), 32'h1);
    check("single_ptr",   32'(dut.ptr),    32'h3);

    // Drain with no winner empties the register, ptr holds.
    step();
    check("drain_valid", 32'(outs_valid), 32'h0);
    check("drain_ptr",   32'(dut.ptr),    32'h3);

    // Requester 3 wraps ptr to 0.
    ctrl_valid = 4'b1000;
    step();
    check("wrap_idx", 32'(outs_idx), 32'h3);
    check("wrap_ptr", 32'(dut.ptr),  32'h0);

    // All requesting: one token per cycle in round-robin order.
    ctrl_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_idx",   32'(outs_idx),   32'(i % 4));
      check("rr_outs",  outs,            32'(32'h44 + (i % 4)));
      check("rr_valid", 32'(outs_valid), 32'h1);
    end

    // Back-pressure: register holds idx 0, ptr=1.
    outs_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(ctrl_ready), 32'h0);
      step();
      check("bp_outs",  outs,            32'h44);
      check("bp_idx",   32'(outs_idx),   32'h0);
      check("bp_valid", 32'(outs_valid), 32'h1);
    end

    // Withdrawn request leaves ptr unchanged.
    ctrl_valid = 4'b0000;
    step();
    check("withdraw_ptr", 32'(dut.ptr), 32'h1);

    // Drain and refill in the same cycle.
    ctrl_valid = 4'b0010;
    outs_ready = 1'b1;
    #1;
    check("refill_ready", 32'(ctrl_ready), 32'h2);
    step();
    check("refill_idx",   32'(outs_idx),   32'h1);
    check("refill_outs",  outs,            32'h45);
    check("refill_valid", 32'(outs_valid), 32'h1);

    // Reset between edges mid-stream.
    ctrl_valid = 4'b1111;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(outs_valid), 32'h0);
    check("midrst_outs",  outs,            32'h0);
    check("midrst_ready", 32'(ctrl_ready), 32'h0);
    check("midrst_ptr",   32'(dut.ptr),    32'h0);
    step();
    rst = 1'b1;
    check("post_rst_valid", 32'(outs_valid), 32'h0);
    step();
    check("post_rst_idx",   32'(outs_idx),   32'h0);
    check("post_rst_valid2", 32'(outs_valid), 32'h1);

`ifdef HANDSHAKE_CONST_ARB_ISSUE_CNT_EN
    check("cnt_start", 32'(issue_cnt), 32'h0);
    for (int i = 0; i < 10; i++) step();
    check("cnt_ten", 32'(issue_cnt), 32'd10);
    for (int i = 0; i < 65525; i++) step();
    check("cnt_max",  32'(issue_cnt), 32'hFFFF);
    step();
    check("cnt_wrap", 32'(issue_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
